// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back queue.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Write-back queue bus: offer side, register-file write side and bypass lookup.
interface wb_queue_if
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                        InValid;
  logic [REG_ADDR_W-1:0]       InReg;
  logic [DATA_W-1:0]           InData;
  logic                        InReady;
  logic                        DrainEn;
  logic [REG_ADDR_W-1:0]       WriteRegister;
  logic [DATA_W-1:0]           WriteData_reg;
  logic                        RegWrite;
  logic [REG_ADDR_W-1:0]       ReadRegister1;
  logic [REG_ADDR_W-1:0]       ReadRegister2;
  logic                        BypassHit1;
  logic                        BypassHit2;
  logic [DATA_W-1:0]           BypassData1;
  logic [DATA_W-1:0]           BypassData2;
  logic [$clog2(DEPTH):0]      Count;

  // Pipeline side: execute/decode/register-file control.
  modport master (
    output InValid, InReg, InData, DrainEn, ReadRegister1, ReadRegister2,
    input  InReady, WriteRegister, WriteData_reg, RegWrite,
           BypassHit1, BypassHit2, BypassData1, BypassData2, Count
  );

  // Queue side.
  modport slave (
    input  InValid, InReg, InData, DrainEn, ReadRegister1, ReadRegister2,
    output InReady, WriteRegister, WriteData_reg, RegWrite,
           BypassHit1, BypassHit2, BypassData1, BypassData2, Count
  );

endinterface

// File: rtl/wbq_storage.sv
// Entry array for the write-back queue: one write port, whole array visible.
module wbq_storage
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  wb_entry_t                    wentry_i,
  output wb_entry_t [DEPTH-1:0]        mem_o
);

  wb_entry_t [DEPTH-1:0] mem_q;

  // Write the accepted entry at the tail slot.
  // NOTE: storage has no reset; validity comes from the pointers and Count, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wentry_i;
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers execute results until the register-file write port is free.
// Optional bypass lookup enabled by defining WBQ_BYPASS_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  reg_write_q, reg_write_d;
  logic                  in_ready, store, pop;
  wb_entry_t [DEPTH-1:0] mem;
  wb_entry_t             head_entry;

  wbq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk      (clk),
    .we_i     (store),
    .waddr_i  (tail_q),
    .wentry_i ('{addr: bus.InReg, data: bus.InData}),
    .mem_o    (mem)
  );

  assign head_entry = mem[head_q];

  // Handshake, pointer, count and output-register next state.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_ready    = (count_q != CNT_W'(DEPTH));
    store       = bus.InValid && in_ready && (bus.InReg != '0);
    pop         = bus.DrainEn && (count_q != '0);
    head_d      = head_q + PTR_W'(pop);
    tail_d      = tail_q + PTR_W'(store);
    count_d     = count_q + CNT_W'(store) - CNT_W'(pop);
    reg_write_d = pop;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (pop) begin
      wr_reg_d  = head_entry.addr;
      wr_data_d = head_entry.data;
    end
  end

  // Queue state and output register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign bus.InReady       = in_ready;
  assign bus.Count         = count_q;
  assign bus.WriteRegister = wr_reg_q;
  assign bus.WriteData_reg = wr_data_q;
  assign bus.RegWrite      = reg_write_q;

`ifdef WBQ_BYPASS_EN
  // Scan oldest to newest so the newest match overrides; output register is oldest.
  function automatic void lookup(input  logic [REG_ADDR_W-1:0] rd,
                                 output logic                  hit,
                                 output logic [DATA_W-1:0]     data);
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    if (rd != '0) begin
      if (reg_write_q && (wr_reg_q == rd)) begin
        hit  = 1'b1;
        data = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem[idx].addr == rd)) begin
          hit  = 1'b1;
          data = mem[idx].data;
        end
      end
    end
  endfunction

  logic              hit1, hit2;
  logic [DATA_W-1:0] data1, data2;

  // Combinational bypass lookup for both decode read ports.
  always_comb begin
    lookup(bus.ReadRegister1, hit1, data1);
    lookup(bus.ReadRegister2, hit2, data2);
  end

  assign bus.BypassHit1  = hit1;
  assign bus.BypassHit2  = hit2;
  assign bus.BypassData1 = data1;
  assign bus.BypassData2 = data2;
`else
  logic unused_rd;
  assign unused_rd       = ^{bus.ReadRegister1, bus.ReadRegister2};
  assign bus.BypassHit1  = 1'b0;
  assign bus.BypassHit2  = 1'b0;
  assign bus.BypassData1 = '0;
  assign bus.BypassData2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4). Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_wb_queue;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_queue_if #(.DEPTH(4)) bus ();

  wb_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.InValid = v;
    bus.InReg   = r;
    bus.InData  = d;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    offer(1'b0, 5'd0, 32'h0);
    bus.DrainEn       = 1'b0;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;

    // Reset state
    tick(); tick();
    check("rst_count",  32'(bus.Count), 32'd0);
    check("rst_regwr",  32'(bus.RegWrite), 32'd0);
    check("rst_wreg",   32'(bus.WriteRegister), 32'd0);
    check("rst_wdata",  bus.WriteData_reg, 32'h0);
    check("rst_ready",  32'(bus.InReady), 32'd1);
    rst_n = 1'b1;
    tick();

    // Minimum latency: offer with DrainEn high, pop on the following edge
    offer(1'b1, 5'd5, 32'hDEADBEEF);
    bus.DrainEn = 1'b1;
    #1 check("lat_ready", 32'(bus.InReady), 32'd1);
    tick();
    check("lat_count1", 32'(bus.Count), 32'd1);
    check("lat_nopop",  32'(bus.RegWrite), 32'd0);
    offer(1'b0, 5'd0, 32'h0);
    tick();
    check("lat_regwr",  32'(bus.RegWrite), 32'd1);
    check("lat_wreg",   32'(bus.WriteRegister), 32'd5);
    check("lat_wdata",  bus.WriteData_reg, 32'hDEADBEEF);
    check("lat_count0", 32'(bus.Count), 32'd0);
    tick();
    check("lat_strobe_off", 32'(bus.RegWrite), 32'd0);
    check("lat_hold_wreg",  32'(bus.WriteRegister), 32'd5);
    check("lat_hold_wdata", bus.WriteData_reg, 32'hDEADBEEF);

    // Offer to register 0: handshake only
    offer(1'b1, 5'd0, 32'h1234);
    #1 check("r0_ready", 32'(bus.InReady), 32'd1);
    tick();
    check("r0_count", 32'(bus.Count), 32'd0);
    check("r0_regwr", 32'(bus.RegWrite), 32'd0);
    offer(1'b0, 5'd0, 32'h0);
    tick();
    check("r0_regwr2", 32'(bus.RegWrite), 32'd0);

    // Fill to DEPTH with drain held off, then drain in order
    bus.DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    check("full_count", 32'(bus.Count), 32'd4);
    check("full_ready", 32'(bus.InReady), 32'd0);
    offer(1'b1, 5'd5, 32'h555);
    tick();
    check("full_reject_count", 32'(bus.Count), 32'd4);
    check("full_no_strobe",    32'(bus.RegWrite), 32'd0);
    offer(1'b0, 5'd0, 32'h0);
    bus.DrainEn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("drain%0d_regwr", i), 32'(bus.RegWrite), 32'd1);
      check($sformatf("drain%0d_wreg", i),  32'(bus.WriteRegister), 32'(i));
      check($sformatf("drain%0d_wdata", i), bus.WriteData_reg, 32'h100 + 32'(i));
      check($sformatf("drain%0d_count", i), 32'(bus.Count), 32'(4 - i));
    end
    tick();
    check("drain_done_regwr", 32'(bus.RegWrite), 32'd0);
    check("drain_done_wreg",  32'(bus.WriteRegister), 32'd4);

    // Bypass: newest of two pending writes to reg 7 wins
    bus.DrainEn = 1'b0;
    offer(1'b1, 5'd7, 32'hA);
    tick();
    offer(1'b1, 5'd7, 32'hB);
    tick();
    offer(1'b0, 5'd0, 32'h0);
    bus.ReadRegister1 = 5'd7;
    bus.ReadRegister2 = 5'd9;
    #1;
    check("byp_hit1",  32'(bus.BypassHit1), 32'(BYP));
    check("byp_data1", bus.BypassData1, BYP ? 32'hB : 32'h0);
    check("byp_hit2",  32'(bus.BypassHit2), 32'd0);
    check("byp_data2", bus.BypassData2, 32'h0);
    bus.ReadRegister1 = 5'd0;
    #1;
    check("byp_r0_hit",  32'(bus.BypassHit1), 32'd0);
    check("byp_r0_data", bus.BypassData1, 32'h0);
    bus.ReadRegister1 = 5'd7;
    bus.DrainEn = 1'b1;
    tick();
    check("byp_pop1_wdata", bus.WriteData_reg, 32'hA);
    check("byp_pop1_data1", bus.BypassData1, BYP ? 32'hB : 32'h0);
    tick();
    check("byp_outreg_wdata", bus.WriteData_reg, 32'hB);
    check("byp_outreg_hit1",  32'(bus.BypassHit1), 32'(BYP));
    check("byp_outreg_data1", bus.BypassData1, BYP ? 32'hB : 32'h0);
    tick();
    check("byp_idle_hit1",  32'(bus.BypassHit1), 32'd0);
    check("byp_idle_data1", bus.BypassData1, 32'h0);
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;

    // Full with simultaneous pop and offer, then reset mid-drain
    bus.DrainEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'd10 + 5'(i), 32'h200 + 32'(i));
      tick();
    end
    check("f2_count", 32'(bus.Count), 32'd4);
    offer(1'b1, 5'd14, 32'h2E);
    bus.DrainEn = 1'b1;
    #1 check("f2_ready_popcycle", 32'(bus.InReady), 32'd0);
    tick();
    check("f2_count3", 32'(bus.Count), 32'd3);
    check("f2_ready1", 32'(bus.InReady), 32'd1);
    check("f2_wreg10", 32'(bus.WriteRegister), 32'd10);
    check("f2_wdata",  bus.WriteData_reg, 32'h200);
    tick();
    check("f2_accpop_count", 32'(bus.Count), 32'd3);
    check("f2_wreg11",       32'(bus.WriteRegister), 32'd11);
    check("f2_wdata11",      bus.WriteData_reg, 32'h201);
    offer(1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_regwr", 32'(bus.RegWrite), 32'd0);
    check("mr_count", 32'(bus.Count), 32'd0);
    check("mr_wreg",  32'(bus.WriteRegister), 32'd0);
    check("mr_wdata", bus.WriteData_reg, 32'h0);
    check("mr_ready", 32'(bus.InReady), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_regwr", i), 32'(bus.RegWrite), 32'd0);
      check($sformatf("post_rst%0d_count", i), 32'(bus.Count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 InValid  input  1  execute stage offers a write-back.
REQ-005 InReg  input  5  destination register of offered write.
REQ-006 InData  input  32  result data of offered write.
REQ-007 InReady  output  1  queue accepts offer this cycle.
REQ-008 DrainEn  input  1  register-file write port free this cycle.
REQ-009 WriteRegister  output  5  register-file write address.
REQ-010 WriteData_reg  output  32  register-file write data.
REQ-011 RegWrite  output  1  register-file write strobe.
REQ-012 ReadRegister1, ReadRegister2  input  5 each  decode-stage read addresses for bypass lookup.
REQ-013 BypassHit1, BypassHit2  output  1 each  pending write exists for the matching read address.
REQ-014 BypassData1, BypassData2  output  32 each  newest pending data for the matching read address.
REQ-015 Count  output  clog2(DEPTH)+1  occupied entries, excluding the output register.

Function
REQ-016 InReady SHALL equal (Count != DEPTH) and be derived from registered state only.
REQ-017 An offer SHALL be accepted on an edge where InValid && InReady; the entry is written at the tail and Count increments.
REQ-018 An accepted offer with InReg == 0 SHALL be handshaked but not stored; Count is unchanged.
REQ-019 On an edge where DrainEn && Count != 0, the head entry SHALL be popped into WriteRegister/WriteData_reg, and RegWrite SHALL be 1 for the following cycle only.
REQ-020 On any edge without a pop, RegWrite SHALL be 0; WriteRegister/WriteData_reg hold their values.
REQ-021 Pop and accept on the same edge SHALL leave Count unchanged; both pointers advance.
REQ-022 Accept into an empty queue with DrainEn high on the same edge SHALL NOT pop; minimum latency is offer edge k -> pop edge k+1 -> RegWrite high between edges k+1 and k+2.
REQ-023 Head/tail pointers SHALL wrap modulo DEPTH; full/empty SHALL be decided by Count.
REQ-024 Bypass lookup SHALL be combinational over all valid entries plus the output register while RegWrite=1; newest match wins (tail-most entry, output register oldest).
REQ-025 ReadRegisterN == 0 SHALL give BypassHitN = 0 and BypassDataN = 0; a miss SHALL also give BypassDataN = 0.
REQ-026 Entries SHALL drain strictly in acceptance order; there is no merging of duplicate destinations.

Reset
REQ-027 While rst_n=0: Count=0, pointers=0, RegWrite=0, WriteRegister=0, WriteData_reg=0, InReady=1 once Count=0; storage contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all pending entries immediately; no write strobe after assertion.

Configuration
REQ-029 Macro WBQ_BYPASS_EN: defined -> REQ-024/025 lookup logic present; undefined -> BypassHitN and BypassDataN tied to 0 with no compare logic, all other behaviour identical.

Structure
REQ-030 Shared package wb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32 and typedef wb_entry_t {reg address, data}.
REQ-031 Sub-module wbq_storage SHALL hold the DEPTH x wb_entry_t array with one write port and full-array read-out for lookup; pointers, Count and output register live in wb_queue.

Verification
REQ-032 Reset, then offer (InReg=5, InData=0xDEADBEEF) with DrainEn=1 -> pop next edge; RegWrite high one cycle with WriteRegister=5, WriteData_reg=0xDEADBEEF.
REQ-033 DrainEn=0, offer regs 1..4 -> Count=4, InReady=0; a fifth offer is not accepted; DrainEn=1 -> writes to 1,2,3,4 in order, one per cycle.
REQ-034 Offer InReg=0, InData=0x1234 -> handshake completes, Count stays 0, RegWrite never asserts.
REQ-035 WBQ_BYPASS_EN defined, queue holds reg7=0xA then reg7=0xB, ReadRegister1=7 -> BypassHit1=1, BypassData1=0xB; ReadRegister2=9 -> BypassHit2=0, BypassData2=0.
REQ-036 Queue full, simultaneous pop: InReady stays 0 on that cycle; then InReady=1 with Count=3; assert rst_n=0 mid-drain -> RegWrite=0 and Count=0 with no further writes.
